clock_set_ctrl: RTL and testbench
=================================

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have: clk_inbuilt  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have: reset  in  1  reset, synchronous, active-high; clock clk_inbuilt.
REQ-003 SHALL have: set  in  4  raw asynchronous buttons, active-high: [0] MODE, [1] INC, [2] DEC, [3] SAVE.
REQ-004 SHALL have: tick_1hz  in  1  one-cycle pulse once per second from the timebase.
REQ-005 SHALL have: cur_h1 in 2, cur_h2 in 4, cur_m1 in 3, cur_m2 in 4  current BCD time (hour tens, hour units, minute tens, minute units).
REQ-006 SHALL have: new_h1 out 2, new_h2 out 4, new_m1 out 3, new_m2 out 4  edit registers, BCD.
REQ-007 SHALL have: load  out  1  one-cycle pulse; counters take new_* when high.
REQ-008 SHALL have: run_en  out  1  high only in RUN; counters advance only when high.
REQ-009 SHALL have: field_sel  out  2  digit under edit: 0=H1, 1=H2, 2=M1, 3=M2; 0 in RUN.
REQ-010 SHALL have: blank  out  1  blink control for the selected digit.

Function
REQ-011 Each set bit SHALL pass through a 2-flop synchronizer; a press event SHALL be the rising edge of the synchronized bit, one event per press.
REQ-012 The effect of a press SHALL be visible on outputs exactly 3 clk_inbuilt cycles after the raw bit rises.
REQ-013 The FSM SHALL have states RUN, SET_H1, SET_H2, SET_M1, SET_M2.
REQ-014 RUN + MODE SHALL go to SET_H1 and copy cur_* into new_* in the same cycle.
REQ-015 MODE in SET_H1->SET_H2->SET_M1->SET_M2 SHALL advance one field; SET_M2 + MODE SHALL wrap to SET_H1.
REQ-016 SAVE in any SET state SHALL pulse load for exactly one cycle, hold new_* stable during it, and return to RUN.
REQ-017 SAVE in RUN SHALL be ignored; INC and DEC in RUN SHALL be ignored.
REQ-018 Priority for same-cycle events SHALL be SAVE > MODE > INC/DEC; simultaneous INC and DEC SHALL be ignored.
REQ-019 INC/DEC SHALL modify only the selected field, with wrap-around: H1 0..2, M1 0..5, M2 0..9, H2 0..9 (0..3 when new_h1==2).
REQ-020 When H1 changes to 2 and new_h2>3, new_h2 SHALL clamp to 3 in the same cycle.
REQ-021 In SET states, blank SHALL toggle on each tick_1hz and SHALL be forced to 0 on any press event; it SHALL be 0 in RUN.
REQ-022 run_en SHALL fall in the cycle the FSM leaves RUN and rise in the cycle after load.

Reset
REQ-023 On reset the block SHALL set state=RUN, run_en=1, load=0, field_sel=0, blank=0, new_*=0, and timeout counter=0.
REQ-024 On reset the synchronizer and edge registers SHALL load all ones, so a button held through reset creates no event.
REQ-025 Reset during SET SHALL abort the edit without a load pulse.

Configuration
REQ-026 With SET_TIMEOUT_EN defined, a 5-bit counter SHALL count tick_1hz in SET states and clear on any press event.
REQ-027 With SET_TIMEOUT_EN defined, the 30th tick without a press SHALL return the FSM to RUN without a load pulse.
REQ-028 Without SET_TIMEOUT_EN, the counter SHALL be absent and the FSM SHALL stay in SET states until SAVE or reset.

Verification
REQ-029 Time 12:34; press MODE, INC, SAVE -> new_*=2,2,3,4 (22:34), load high 1 cycle, run_en returns 1.
REQ-030 In SET_H2 with 19:xx: press DEC twice -> new_h2=7; with H2=9, press INC -> new_h2=0.
REQ-031 Time 19:59; MODE, INC -> new_h1=2, new_h2 clamped to 3; in SET_H2, INC from 3 -> 0.
REQ-032 INC and DEC rising in the same cycle -> no change; MODE and SAVE in the same cycle -> SAVE wins, load pulses.
REQ-033 With SET_TIMEOUT_EN: enter SET, issue 30 tick_1hz with no press -> RUN, load never asserted; 29 ticks, INC, then 29 ticks -> still in SET.
REQ-034 Hold MODE across reset release -> no state change until MODE is released and pressed again.

Source files
------------

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: synchronizes the four buttons, edits a BCD copy of the
// clock time field by field, and loads it back on SAVE. Optional macro: SET_TIMEOUT_EN.
module clock_set_ctrl (
  input  logic       clk_inbuilt,
  input  logic       reset,
  input  logic [3:0] set,
  input  logic       tick_1hz,
  input  logic [1:0] cur_h1,
  input  logic [3:0] cur_h2,
  input  logic [2:0] cur_m1,
  input  logic [3:0] cur_m2,
  output logic [1:0] new_h1,
  output logic [3:0] new_h2,
  output logic [2:0] new_m1,
  output logic [3:0] new_m2,
  output logic       load,
  output logic       run_en,
  output logic [1:0] field_sel,
  output logic       blank
);

  // state  | meaning
  // RUN    | clock advancing, edit registers idle
  // SET_H1 | editing hour tens
  // SET_H2 | editing hour units
  // SET_M1 | editing minute tens
  // SET_M2 | editing minute units
  typedef enum logic [2:0] {RUN, SET_H1, SET_H2, SET_M1, SET_M2} state_t;

  state_t     state_q, state_d;
  logic [3:0] sync1_q, sync2_q, edge_q;
  logic [3:0] ev;
  logic       ev_mode, ev_inc, ev_dec, ev_save, any_ev;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h2_q, h2_d;
  logic [2:0] m1_q, m1_d;
  logic [3:0] m2_q, m2_d;
  logic       load_q, load_d;
  logic       run_en_q, run_en_d;
  logic       blank_q, blank_d;
  logic       timeout_hit;
  logic [3:0] h2_max;

  // All ones at reset so a button held through reset produces no edge.
  always_ff @(posedge clk_inbuilt) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      edge_q  <= 4'hF;
    end else begin
      sync1_q <= set;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign ev      = sync2_q & ~edge_q;
  assign ev_mode = ev[0];
  assign ev_inc  = ev[1];
  assign ev_dec  = ev[2];
  assign ev_save = ev[3];
  assign any_ev  = |ev;

`ifdef SET_TIMEOUT_EN
  logic [4:0] to_q, to_d;

  // Thirtieth idle tick in an edit state abandons the edit.
  assign timeout_hit = (state_q != RUN) && tick_1hz && !any_ev && (to_q == 5'd29);

  always_comb begin
    to_d = to_q;
    if (state_d == RUN || any_ev) to_d = 5'd0;
    else if (tick_1hz)            to_d = to_q + 5'd1;
  end

  always_ff @(posedge clk_inbuilt) begin
    if (reset) to_q <= 5'd0;
    else       to_q <= to_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign h2_max = (h1_d == 2'd2) ? 4'd3 : 4'd9;

  always_comb begin
    state_d = state_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    load_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (ev_mode) begin
          state_d = SET_H1;
          h1_d    = cur_h1;
          h2_d    = cur_h2;
          m1_d    = cur_m1;
          m2_d    = cur_m2;
        end
      end
      default: begin
        if (ev_save) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (ev_mode) begin
          case (state_q)
            SET_H1:  state_d = SET_H2;
            SET_H2:  state_d = SET_M1;
            SET_M1:  state_d = SET_M2;
            default: state_d = SET_H1;
          endcase
        end else if (timeout_hit) begin
          state_d = RUN;
        end else if (ev_inc ^ ev_dec) begin
          case (state_q)
            SET_H1: begin
              if (ev_inc) h1_d = (h1_q == 2'd2) ? 2'd0 : h1_q + 2'd1;
              else        h1_d = (h1_q == 2'd0) ? 2'd2 : h1_q - 2'd1;
              if (h1_d == 2'd2 && h2_q > 4'd3) h2_d = 4'd3;
            end
            SET_H2: begin
              if (ev_inc) h2_d = (h2_q >= h2_max) ? 4'd0 : h2_q + 4'd1;
              else        h2_d = (h2_q == 4'd0) ? h2_max : h2_q - 4'd1;
            end
            SET_M1: begin
              if (ev_inc) m1_d = (m1_q >= 3'd5) ? 3'd0 : m1_q + 3'd1;
              else        m1_d = (m1_q == 3'd0) ? 3'd5 : m1_q - 3'd1;
            end
            default: begin
              if (ev_inc) m2_d = (m2_q >= 4'd9) ? 4'd0 : m2_q + 4'd1;
              else        m2_d = (m2_q == 4'd0) ? 4'd9 : m2_q - 4'd1;
            end
          endcase
        end
      end
    endcase

    // run_en stays low through the load cycle so counters take new_* first.
    run_en_d = (state_d == RUN) && !load_d;

    blank_d = blank_q;
    if (state_d == RUN)  blank_d = 1'b0;
    else if (any_ev)     blank_d = 1'b0;
    else if (tick_1hz)   blank_d = ~blank_q;
  end

  always_ff @(posedge clk_inbuilt) begin
    if (reset) begin
      state_q  <= RUN;
      h1_q     <= 2'd0;
      h2_q     <= 4'd0;
      m1_q     <= 3'd0;
      m2_q     <= 4'd0;
      load_q   <= 1'b0;
      run_en_q <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
      load_q   <= load_d;
      run_en_q <= run_en_d;
      blank_q  <= blank_d;
    end
  end

  always_comb begin
    case (state_q)
      SET_H2:  field_sel = 2'd1;
      SET_M1:  field_sel = 2'd2;
      SET_M2:  field_sel = 2'd3;
      default: field_sel = 2'd0;
    endcase
  end

  assign new_h1 = h1_q;
  assign new_h2 = h2_q;
  assign new_m1 = m1_q;
  assign new_m2 = m2_q;
  assign load   = load_q;
  assign run_en = run_en_q;
  assign blank  = blank_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: editing, wrap/clamp, priority, blink, reset and timeout.
module tb_clock_set_ctrl;

  logic       clk_inbuilt = 1'b0;
  logic       reset;
  logic [3:0] set;
  logic       tick_1hz;
  logic [1:0] cur_h1;
  logic [3:0] cur_h2;
  logic [2:0] cur_m1;
  logic [3:0] cur_m2;
  logic [1:0] new_h1;
  logic [3:0] new_h2;
  logic [2:0] new_m1;
  logic [3:0] new_m2;
  logic       load;
  logic       run_en;
  logic [1:0] field_sel;
  logic       blank;

  logic [12:0] nt;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        load_seen;

  assign nt = {new_h1, new_h2, new_m1, new_m2};

  always #5 clk_inbuilt = ~clk_inbuilt;

  always @(posedge clk_inbuilt) if (load === 1'b1) load_seen <= 1'b1;

  clock_set_ctrl dut (
    .clk_inbuilt(clk_inbuilt), .reset(reset), .set(set), .tick_1hz(tick_1hz),
    .cur_h1(cur_h1), .cur_h2(cur_h2), .cur_m1(cur_m1), .cur_m2(cur_m2),
    .new_h1(new_h1), .new_h2(new_h2), .new_m1(new_m1), .new_m2(new_m2),
    .load(load), .run_en(run_en), .field_sel(field_sel), .blank(blank)
  );

  // Raise buttons and stop just after the edge where the press takes effect.
  task automatic press(input logic [3:0] mask);
    @(negedge clk_inbuilt);
    set = mask;
    repeat (3) @(posedge clk_inbuilt);
    #1;
  endtask

  task automatic rel();
    @(negedge clk_inbuilt);
    set = 4'h0;
    repeat (4) @(posedge clk_inbuilt);
    #1;
  endtask

  task automatic tap(input logic [3:0] mask);
    press(mask);
    rel();
  endtask

  task automatic tick();
    @(negedge clk_inbuilt);
    tick_1hz = 1'b1;
    @(negedge clk_inbuilt);
    tick_1hz = 1'b0;
  endtask

  task automatic set_cur(input logic [1:0] a, input logic [3:0] b, input logic [2:0] c, input logic [3:0] d);
    cur_h1 = a; cur_h2 = b; cur_m1 = c; cur_m2 = d;
  endtask

  task automatic do_reset();
    @(negedge clk_inbuilt);
    reset = 1'b1;
    repeat (2) @(negedge clk_inbuilt);
    reset = 1'b0;
    repeat (4) @(negedge clk_inbuilt);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({run_en, load, field_sel, blank} !== 5'b10000) begin
      $display("FAIL reset_ctrl: run_en/load/field/blank=%b expected 10000", {run_en, load, field_sel, blank});
      n_fail++;
    end
    n_tests++;
    if (nt !== 13'd0) begin
      $display("FAIL reset_new: new=%h expected 0", nt);
      n_fail++;
    end
  endtask

  task automatic test_basic_edit();
    set_cur(2'd1, 4'd2, 3'd3, 4'd4);
    @(negedge clk_inbuilt);
    set = 4'h1;
    repeat (2) @(posedge clk_inbuilt);
    #1;
    n_tests++;
    if (run_en !== 1'b1) begin
      $display("FAIL latency_early: run_en=%b expected 1 two cycles after press", run_en);
      n_fail++;
    end
    @(posedge clk_inbuilt);
    #1;
    n_tests++;
    if (run_en !== 1'b0 || field_sel !== 2'd0 || nt !== {2'd1, 4'd2, 3'd3, 4'd4}) begin
      $display("FAIL enter_set: run_en=%b field=%0d new=%h expected 0 0 %h", run_en, field_sel, nt, {2'd1, 4'd2, 3'd3, 4'd4});
      n_fail++;
    end
    rel();
    tap(4'h2);
    n_tests++;
    if (nt !== {2'd2, 4'd2, 3'd3, 4'd4}) begin
      $display("FAIL inc_h1: new=%h expected %h", nt, {2'd2, 4'd2, 3'd3, 4'd4});
      n_fail++;
    end
    press(4'h8);
    n_tests++;
    if (load !== 1'b1 || run_en !== 1'b0 || nt !== {2'd2, 4'd2, 3'd3, 4'd4}) begin
      $display("FAIL save_load: load=%b run_en=%b new=%h expected 1 0 %h", load, run_en, nt, {2'd2, 4'd2, 3'd3, 4'd4});
      n_fail++;
    end
    @(posedge clk_inbuilt);
    #1;
    n_tests++;
    if (load !== 1'b0 || run_en !== 1'b1 || field_sel !== 2'd0) begin
      $display("FAIL save_after: load=%b run_en=%b field=%0d expected 0 1 0", load, run_en, field_sel);
      n_fail++;
    end
    rel();
  endtask

  task automatic test_h2_wrap();
    set_cur(2'd1, 4'd9, 3'd0, 4'd0);
    tap(4'h1);
    tap(4'h1);
    n_tests++;
    if (field_sel !== 2'd1) begin
      $display("FAIL field_h2: field=%0d expected 1", field_sel);
      n_fail++;
    end
    tap(4'h4);
    tap(4'h4);
    n_tests++;
    if (new_h2 !== 4'd7) begin
      $display("FAIL dec_h2: new_h2=%0d expected 7", new_h2);
      n_fail++;
    end
    tap(4'h2);
    tap(4'h2);
    tap(4'h2);
    n_tests++;
    if (new_h2 !== 4'd0) begin
      $display("FAIL inc_h2_wrap: new_h2=%0d expected 0", new_h2);
      n_fail++;
    end
    tap(4'h8);
  endtask

  task automatic test_clamp();
    set_cur(2'd1, 4'd9, 3'd5, 4'd9);
    tap(4'h1);
    tap(4'h2);
    n_tests++;
    if (new_h1 !== 2'd2 || new_h2 !== 4'd3) begin
      $display("FAIL clamp: h1=%0d h2=%0d expected 2 3", new_h1, new_h2);
      n_fail++;
    end
    tap(4'h1);
    tap(4'h2);
    n_tests++;
    if (new_h2 !== 4'd0) begin
      $display("FAIL h2_wrap_at_3: h2=%0d expected 0", new_h2);
      n_fail++;
    end
    tap(4'h4);
    n_tests++;
    if (new_h2 !== 4'd3) begin
      $display("FAIL h2_dec_to_3: h2=%0d expected 3", new_h2);
      n_fail++;
    end
    tap(4'h8);
  endtask

  task automatic test_minutes();
    set_cur(2'd0, 4'd5, 3'd5, 4'd0);
    tap(4'h1);
    tap(4'h4);
    n_tests++;
    if (new_h1 !== 2'd2 || new_h2 !== 4'd3) begin
      $display("FAIL h1_dec_wrap: h1=%0d h2=%0d expected 2 3", new_h1, new_h2);
      n_fail++;
    end
    tap(4'h1);
    tap(4'h1);
    tap(4'h2);
    n_tests++;
    if (field_sel !== 2'd2 || new_m1 !== 3'd0) begin
      $display("FAIL m1_wrap: field=%0d m1=%0d expected 2 0", field_sel, new_m1);
      n_fail++;
    end
    tap(4'h1);
    tap(4'h4);
    n_tests++;
    if (field_sel !== 2'd3 || new_m2 !== 4'd9) begin
      $display("FAIL m2_wrap: field=%0d m2=%0d expected 3 9", field_sel, new_m2);
      n_fail++;
    end
    tap(4'h1);
    n_tests++;
    if (field_sel !== 2'd0 || run_en !== 1'b0) begin
      $display("FAIL mode_wrap: field=%0d run_en=%b expected 0 0", field_sel, run_en);
      n_fail++;
    end
    tap(4'h8);
  endtask

  task automatic test_conflicts();
    set_cur(2'd1, 4'd0, 3'd0, 4'd0);
    tap(4'h1);
    tap(4'h6);
    n_tests++;
    if (new_h1 !== 2'd1) begin
      $display("FAIL inc_dec_same: h1=%0d expected 1", new_h1);
      n_fail++;
    end
    press(4'h9);
    n_tests++;
    if (load !== 1'b1 || field_sel !== 2'd0) begin
      $display("FAIL save_over_mode: load=%b field=%0d expected 1 0", load, field_sel);
      n_fail++;
    end
    rel();
    load_seen = 1'b0;
    tap(4'h8);
    tap(4'h2);
    n_tests++;
    if (load_seen !== 1'b0 || run_en !== 1'b1 || new_h1 !== 2'd1) begin
      $display("FAIL run_ignore: load_seen=%b run_en=%b h1=%0d expected 0 1 1", load_seen, run_en, new_h1);
      n_fail++;
    end
  endtask

  task automatic test_blank();
    n_tests++;
    if (blank !== 1'b0) begin
      $display("FAIL blank_run_tick_pre: blank=%b expected 0", blank);
      n_fail++;
    end
    tick();
    n_tests++;
    if (blank !== 1'b0) begin
      $display("FAIL blank_run: blank=%b expected 0", blank);
      n_fail++;
    end
    tap(4'h1);
    tick();
    n_tests++;
    if (blank !== 1'b1) begin
      $display("FAIL blank_tick1: blank=%b expected 1", blank);
      n_fail++;
    end
    tick();
    tick();
    n_tests++;
    if (blank !== 1'b1) begin
      $display("FAIL blank_tick3: blank=%b expected 1", blank);
      n_fail++;
    end
    tap(4'h2);
    n_tests++;
    if (blank !== 1'b0) begin
      $display("FAIL blank_press: blank=%b expected 0", blank);
      n_fail++;
    end
    tick();
    tap(4'h8);
    n_tests++;
    if (blank !== 1'b0) begin
      $display("FAIL blank_after_save: blank=%b expected 0", blank);
      n_fail++;
    end
  endtask

  task automatic test_reset_abort();
    set_cur(2'd1, 4'd1, 3'd1, 4'd1);
    tap(4'h1);
    tap(4'h2);
    load_seen = 1'b0;
    do_reset();
    n_tests++;
    if (load_seen !== 1'b0 || run_en !== 1'b1 || nt !== 13'd0) begin
      $display("FAIL reset_abort: load_seen=%b run_en=%b new=%h expected 0 1 0", load_seen, run_en, nt);
      n_fail++;
    end
  endtask

  task automatic test_hold_reset();
    @(negedge clk_inbuilt);
    set = 4'h1;
    do_reset();
    repeat (4) @(negedge clk_inbuilt);
    n_tests++;
    if (run_en !== 1'b1) begin
      $display("FAIL hold_through_reset: run_en=%b expected 1", run_en);
      n_fail++;
    end
    rel();
    n_tests++;
    if (run_en !== 1'b1) begin
      $display("FAIL hold_release: run_en=%b expected 1", run_en);
      n_fail++;
    end
    tap(4'h1);
    n_tests++;
    if (run_en !== 1'b0) begin
      $display("FAIL hold_repress: run_en=%b expected 0", run_en);
      n_fail++;
    end
    tap(4'h8);
  endtask

  task automatic test_timeout();
    load_seen = 1'b0;
    tap(4'h1);
`ifdef SET_TIMEOUT_EN
    repeat (29) tick();
    tap(4'h2);
    repeat (29) tick();
    n_tests++;
    if (run_en !== 1'b0) begin
      $display("FAIL timeout_press_clears: run_en=%b expected 0", run_en);
      n_fail++;
    end
    tick();
    @(negedge clk_inbuilt);
    n_tests++;
    if (run_en !== 1'b1 || load_seen !== 1'b0) begin
      $display("FAIL timeout_30: run_en=%b load_seen=%b expected 1 0", run_en, load_seen);
      n_fail++;
    end
`else
    repeat (40) tick();
    n_tests++;
    if (run_en !== 1'b0 || load_seen !== 1'b0) begin
      $display("FAIL no_timeout: run_en=%b load_seen=%b expected 0 0", run_en, load_seen);
      n_fail++;
    end
    tap(4'h8);
`endif
  endtask

  initial begin
    reset = 1'b1;
    set = 4'h0;
    tick_1hz = 1'b0;
    load_seen = 1'b0;
    set_cur(2'd0, 4'd0, 3'd0, 4'd0);
    test_reset();
    test_basic_edit();
    test_h2_wrap();
    test_clamp();
    test_minutes();
    test_conflicts();
    test_blank();
    test_reset_abort();
    test_hold_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
